bc_display_mux: RTL and testbench

- Downstream display stage of the Bulls & Cows game on Nexys A7.
- Consumes the game core's status: current 4-digit entry or guess, bulls/cows counts, active player and display mode.
- Drives the 8-digit multiplexed seven-segment display (an, digit).
- Owns scan timing, frame-coherent input snapshotting and blink; contains no game logic.

---
 rtl/bc_pkg.sv | 74 +++++++
 rtl/bc_display_mux_seg7_encode.sv | 42 ++++
 rtl/bc_display_mux.sv | 160 ++++++++++++++++
 tb/tb_bc_display_mux.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// Shared types and constants for the Bulls & Cows seven-segment display path.
// Latency: n/a (types, constants and one pure helper only).
// Backpressure: n/a.
package bc_pkg;

    localparam int NUM_DIGITS = 8;

    typedef enum logic [1:0] {
        MODE_BLANK  = 2'd0,
        MODE_DIGITS = 2'd1,
        MODE_RESULT = 2'd2,
        MODE_WIN    = 2'd3
    } display_mode_t;

    // Hex glyphs occupy codes 0..15 so a nibble maps straight onto its glyph.
    typedef enum logic [4:0] {
        G_0     = 5'd0,
        G_1     = 5'd1,
        G_2     = 5'd2,
        G_3     = 5'd3,
        G_4     = 5'd4,
        G_5     = 5'd5,
        G_6     = 5'd6,
        G_7     = 5'd7,
        G_8     = 5'd8,
        G_9     = 5'd9,
        G_A     = 5'd10,
        G_B     = 5'd11,
        G_C     = 5'd12,
        G_D     = 5'd13,
        G_E     = 5'd14,
        G_F     = 5'd15,
        G_P     = 5'd16,
        G_LB    = 5'd17,
        G_LC    = 5'd18,
        G_LD    = 5'd19,
        G_LO    = 5'd20,
        G_LN    = 5'd21,
        G_BLANK = 5'd22
    } glyph_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_LB    = 7'b0000011;
    localparam logic [6:0] SEG_LC    = 7'b0100111;
    localparam logic [6:0] SEG_LD    = 7'b0100001;
    localparam logic [6:0] SEG_LO    = 7'b0100011;
    localparam logic [6:0] SEG_LN    = 7'b0101011;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [7:0] AN_OFF = 8'hFF;

    // A 4-bit value (hex nibble or 0..7 count) as its digit glyph.
    function automatic glyph_t hex_glyph(input logic [3:0] nib);
        return glyph_t'({1'b0, nib});
    endfunction

endpackage

// File: rtl/bc_display_mux_seg7_encode.sv
// Glyph to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Latency: combinational.
// Backpressure: none.
module seg7_encode
    import bc_pkg::*;
(
    input  glyph_t     glyph,
    output logic [6:0] seg
);

    // Lookup of the segment pattern for the requested glyph; unknown codes go dark.
    always_comb begin
        seg = SEG_BLANK;
        case (glyph)
            G_0:     seg = SEG_0;
            G_1:     seg = SEG_1;
            G_2:     seg = SEG_2;
            G_3:     seg = SEG_3;
            G_4:     seg = SEG_4;
            G_5:     seg = SEG_5;
            G_6:     seg = SEG_6;
            G_7:     seg = SEG_7;
            G_8:     seg = SEG_8;
            G_9:     seg = SEG_9;
            G_A:     seg = SEG_A;
            G_B:     seg = SEG_B;
            G_C:     seg = SEG_C;
            G_D:     seg = SEG_D;
            G_E:     seg = SEG_E;
            G_F:     seg = SEG_F;
            G_P:     seg = SEG_P;
            G_LB:    seg = SEG_LB;
            G_LC:    seg = SEG_LC;
            G_LD:    seg = SEG_LD;
            G_LO:    seg = SEG_LO;
            G_LN:    seg = SEG_LN;
            G_BLANK: seg = SEG_BLANK;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bc_display_mux.sv
// Scans the 8-digit seven-segment display from a per-frame snapshot of game status, with blink.
// Latency: inputs latched at the frame wrap; an/digit registered one cycle after the scan index.
// Backpressure: none; inputs are sampled, never acknowledged.
module bc_display_mux
    import bc_pkg::*;
#(
    parameter int SCAN_DIV  = 12500,
    parameter int BLINK_DIV = 50000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic [15:0] value,
    input  logic [2:0]  bulls,
    input  logic [2:0]  cows,
    input  logic        player,
    input  logic        blink_en,
    output logic [7:0]  an,
    output logic [6:0]  digit
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [SCAN_W-1:0]  scan_cnt;
    logic [IDX_W-1:0]   idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    display_mode_t      snap_mode;
    logic [15:0]        snap_value;
    logic [2:0]         snap_bulls;
    logic [2:0]         snap_cows;
    logic               snap_player;
    logic               snap_blink_en;

    logic               scan_tick;
    logic               frame_wrap;
    logic               hidden;
    glyph_t             glyph;
    logic [6:0]         seg;

    assign scan_tick  = (scan_cnt == SCAN_LAST);
    assign frame_wrap = scan_tick && (idx == IDX_LAST);

    // Digit dwell counter and scan index; index steps once per dwell period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_tick) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Frame-coherent snapshot: inputs only take effect at the 7 -> 0 wrap so a frame never tears.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap_mode     <= MODE_BLANK;
            snap_value    <= '0;
            snap_bulls    <= '0;
            snap_cows     <= '0;
            snap_player   <= 1'b0;
            snap_blink_en <= 1'b0;
        end else if (frame_wrap) begin
            snap_mode     <= display_mode_t'(mode);
            snap_value    <= value;
            snap_bulls    <= bulls;
            snap_cows     <= cows;
            snap_player   <= player;
            snap_blink_en <= blink_en;
        end
    end

    // Blink half-period timer; held at the visible phase while blinking is off so it always starts lit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (!snap_blink_en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    // Per-position glyph selection from the snapshot; idx 7 is the leftmost digit.
    always_comb begin
        glyph = G_BLANK;
        case (snap_mode)
            MODE_DIGITS: begin
                case (idx)
                    3'd7:    glyph = G_P;
                    3'd6:    glyph = snap_player ? G_2 : G_1;
                    3'd3:    glyph = hex_glyph(snap_value[15:12]);
                    3'd2:    glyph = hex_glyph(snap_value[11:8]);
                    3'd1:    glyph = hex_glyph(snap_value[7:4]);
                    3'd0:    glyph = hex_glyph(snap_value[3:0]);
                    default: glyph = G_BLANK;
                endcase
            end
            MODE_RESULT: begin
                case (idx)
                    3'd7:    glyph = hex_glyph({1'b0, snap_bulls});
                    3'd6:    glyph = G_LB;
                    3'd4:    glyph = hex_glyph({1'b0, snap_cows});
                    3'd3:    glyph = G_LC;
                    default: glyph = G_BLANK;
                endcase
            end
            MODE_WIN: begin
                case (idx)
                    3'd7:    glyph = G_P;
                    3'd6:    glyph = snap_player ? G_2 : G_1;
                    3'd3:    glyph = G_LD;
                    3'd2:    glyph = G_LO;
                    3'd1:    glyph = G_LN;
                    3'd0:    glyph = G_E;
                    default: glyph = G_BLANK;
                endcase
            end
            default: glyph = G_BLANK;
        endcase
    end

    seg7_encode u_seg7 (
        .glyph (glyph),
        .seg   (seg)
    );

    // Whole display goes dark for BLANK mode or the off half of a blink.
    assign hidden = (snap_mode == MODE_BLANK) || (snap_blink_en && !blink_phase);

    // Registered anode/segment drive so the pins are glitch-free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an    <= AN_OFF;
            digit <= SEG_BLANK;
        end else if (hidden) begin
            an    <= AN_OFF;
            digit <= SEG_BLANK;
        end else begin
            an    <= ~(8'b1 << idx);
            digit <= seg;
        end
    end

endmodule

// File: tb/tb_bc_display_mux.sv
// Directed bench for bc_display_mux with a short scan (4 cycles/digit) and blink (64 cycles).
// Latency: n/a.
// Backpressure: n/a.
module tb_bc_display_mux;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic [15:0] value;
    logic [2:0]  bulls;
    logic [2:0]  cows;
    logic        player;
    logic        blink_en;
    logic [7:0]  an;
    logic [6:0]  digit;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] cap_an   [8];
    logic [6:0] cap_dig  [8];
    logic       cap_hold [8];

    logic [7:0] an_pos [8];
    logic [6:0] exp_dig [8];

    bc_display_mux #(
        .SCAN_DIV  (4),
        .BLINK_DIV (64)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .mode     (mode),
        .value    (value),
        .bulls    (bulls),
        .cows     (cows),
        .player   (player),
        .blink_en (blink_en),
        .an       (an),
        .digit    (digit)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // Advance n rising edges, landing on the following falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    // Record one full frame starting just after a wrap; optionally change value at a given offset.
    task automatic capture_frame(input int chg_off, input logic [15:0] chg_val);
        logic [7:0] a0;
        logic [6:0] d0;
        logic       same;
        for (int p = 0; p < 8; p++) begin
            same = 1'b1;
            a0   = '0;
            d0   = '0;
            for (int k = 0; k < 4; k++) begin
                step(1);
                if (p * 4 + k + 1 == chg_off) value = chg_val;
                if (k == 0) begin
                    a0 = an;
                    d0 = digit;
                end else if (an !== a0 || digit !== d0) begin
                    same = 1'b0;
                end
            end
            cap_an[p]   = a0;
            cap_dig[p]  = d0;
            cap_hold[p] = same;
        end
    endtask

    task automatic test_reset;
        int bad;
        reset    = 1'b1;
        mode     = 2'd1;
        value    = 16'h1234;
        bulls    = 3'd0;
        cows     = 3'd0;
        player   = 1'b0;
        blink_en = 1'b0;
        step(3);
        checks++;
        if (an !== 8'hFF || digit !== 7'h7F) begin
            errors++;
            $display("FAIL reset_outputs: an=%h digit=%h, want an=ff digit=7f", an, digit);
        end
        reset = 1'b0;
        cyc   = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) begin
            step(1);
            if (an !== 8'hFF || digit !== 7'h7F) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL first_frame_dark: %0d lit cycles, want 0", bad);
        end
    endtask

    task automatic test_digits;
        capture_frame(-1, 16'h0);
        exp_dig = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h79, 7'h0C};
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (cap_an[p] !== an_pos[p]) begin
                errors++;
                $display("FAIL digits_an pos%0d: got %h, want %h", p, cap_an[p], an_pos[p]);
            end
            checks++;
            if (cap_dig[p] !== exp_dig[p]) begin
                errors++;
                $display("FAIL digits_seg pos%0d: got %b, want %b", p, cap_dig[p], exp_dig[p]);
            end
            checks++;
            if (cap_hold[p] !== 1'b1) begin
                errors++;
                $display("FAIL digits_hold pos%0d: output changed within its 4-cycle slot", p);
            end
        end
    endtask

    task automatic test_result;
        mode  = 2'd2;
        bulls = 3'd2;
        cows  = 3'd1;
        step(32);
        capture_frame(-1, 16'h0);
        exp_dig = '{7'h7F, 7'h7F, 7'h7F, 7'h27, 7'h79, 7'h7F, 7'h03, 7'h24};
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (cap_an[p] !== an_pos[p] || cap_dig[p] !== exp_dig[p]) begin
                errors++;
                $display("FAIL result pos%0d: an=%h seg=%b, want an=%h seg=%b",
                         p, cap_an[p], cap_dig[p], an_pos[p], exp_dig[p]);
            end
        end
    endtask

    task automatic test_snapshot;
        mode  = 2'd1;
        value = 16'h1234;
        step(32);
        capture_frame(12, 16'h5678);
        exp_dig = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h79, 7'h0C};
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (cap_dig[p] !== exp_dig[p]) begin
                errors++;
                $display("FAIL snapshot_old pos%0d: seg=%b, want %b", p, cap_dig[p], exp_dig[p]);
            end
        end
        capture_frame(-1, 16'h0);
        exp_dig = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h7F, 7'h7F, 7'h79, 7'h0C};
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (cap_an[p] !== an_pos[p] || cap_dig[p] !== exp_dig[p]) begin
                errors++;
                $display("FAIL snapshot_new pos%0d: an=%h seg=%b, want an=%h seg=%b",
                         p, cap_an[p], cap_dig[p], an_pos[p], exp_dig[p]);
            end
        end
    endtask

    task automatic test_blink;
        int bad;
        mode     = 2'd3;
        player   = 1'b1;
        blink_en = 1'b1;
        step(32);
        exp_dig = '{7'h06, 7'h2B, 7'h23, 7'h21, 7'h7F, 7'h7F, 7'h24, 7'h0C};
        for (int f = 0; f < 2; f++) begin
            capture_frame(-1, 16'h0);
            for (int p = 0; p < 8; p++) begin
                checks++;
                if (cap_an[p] !== an_pos[p] || cap_dig[p] !== exp_dig[p]) begin
                    errors++;
                    $display("FAIL blink_on%0d pos%0d: an=%h seg=%b, want an=%h seg=%b",
                             f, p, cap_an[p], cap_dig[p], an_pos[p], exp_dig[p]);
                end
            end
        end
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            step(1);
            if (an !== 8'hFF || digit !== 7'h7F) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL blink_off: %0d lit cycles in off half-period, want 0", bad);
        end
        capture_frame(-1, 16'h0);
        checks++;
        if (cap_an[7] !== 8'h7F || cap_dig[7] !== 7'h0C) begin
            errors++;
            $display("FAIL blink_relit: an=%h seg=%b, want an=7f seg=0001100", cap_an[7], cap_dig[7]);
        end
        blink_en = 1'b0;
        step(32);
        capture_frame(-1, 16'h0);
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (cap_an[p] !== an_pos[p] || cap_dig[p] !== exp_dig[p]) begin
                errors++;
                $display("FAIL blink_dropped pos%0d: an=%h seg=%b, want an=%h seg=%b",
                         p, cap_an[p], cap_dig[p], an_pos[p], exp_dig[p]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        int bad;
        step(21);
        checks++;
        if (an !== 8'hDF || digit !== 7'h7F) begin
            errors++;
            $display("FAIL pre_reset_idx5: an=%h digit=%h, want an=df digit=7f", an, digit);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (an !== 8'hFF || digit !== 7'h7F) begin
            errors++;
            $display("FAIL async_reset: an=%h digit=%h, want an=ff digit=7f", an, digit);
        end
        step(2);
        reset = 1'b0;
        cyc   = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) begin
            step(1);
            if (an !== 8'hFF || digit !== 7'h7F) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL post_reset_dark: %0d lit cycles, want 0", bad);
        end
        capture_frame(-1, 16'h0);
        exp_dig = '{7'h06, 7'h2B, 7'h23, 7'h21, 7'h7F, 7'h7F, 7'h24, 7'h0C};
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (cap_an[p] !== an_pos[p] || cap_dig[p] !== exp_dig[p]) begin
                errors++;
                $display("FAIL post_reset_win pos%0d: an=%h seg=%b, want an=%h seg=%b",
                         p, cap_an[p], cap_dig[p], an_pos[p], exp_dig[p]);
            end
        end
    endtask

    task automatic test_blank;
        int bad;
        mode     = 2'd0;
        blink_en = 1'b0;
        step(32);
        bad = 0;
        for (int i = 0; i < 96; i++) begin
            step(1);
            if (an !== 8'hFF || digit !== 7'h7F) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL blank_mode: %0d lit cycles over 3 frames, want 0", bad);
        end
    endtask

    initial begin
        an_pos = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        test_reset;
        test_digits;
        test_result;
        test_snapshot;
        test_blink;
        test_reset_midframe;
        test_blank;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
